sdram_traffic_gen: RTL and testbench
====================================

// Module: sdram_traffic_gen
// PURPOSE
//  Synthesizable, parametrised traffic generator/checker for the sdram_controller host port.
//  - Issues NUM_XFERS writes from BASE_ADDR with a configurable stride, then reads them back.
//  - Compares each read word with the recomputed pattern.
//  - Two run modes: block (all writes, then all reads) and interleaved (write i, read i).
//  - Reports pass/fail, error count, first failing address and ack timeouts.
//  - Replaces hand-written bench tasks for on-board and regression bring-up.
// PARAMETERS
//  FPGA_ADDR_WIDTH   23          host address width
//  FPGA_DATA_WIDTH   32          host data width
//  NUM_XFERS         16          addresses per run; >=1
//  ADDR_STRIDE       1           address increment per transfer
//  BASE_ADDR         0           first address; FPGA_ADDR_WIDTH bits
//  SEED              32'hA5A5_0000  pattern seed
//  ACK_TIMEOUT       1024        cycles to wait for fpga_ack before abort; >=2
//  ERR_CNT_WIDTH     16          width of err_count
// PORTS
//  fpga_clk        in   1        system clock
//  fpga_reset      in   1        async reset
//  start           in   1        1-cycle pulse; starts a run when idle
//  mode            in   1        0 = block, 1 = interleaved; sampled on start
//  fpga_addr       out  FPGA_ADDR_WIDTH  host address to controller
//  fpga_wr_en      out  1        write request qualifier
//  fpga_wr_data    out  FPGA_DATA_WIDTH  write data
//  fpga_rd_en      out  1        read request qualifier
//  fpga_req        out  1        request strobe
//  fpga_ack        in   1        controller acknowledge
//  fpga_rd_data    in   FPGA_DATA_WIDTH  read data, valid in the ack cycle
//  busy            out  1        run in progress
//  done            out  1        sticky; cleared by the next accepted start
//  pass            out  1        valid when done: err_count==0 and no timeout
//  timeout         out  1        sticky; the run was aborted on an ack timeout
//  err_count       out  ERR_CNT_WIDTH  saturating mismatch count
//  first_err_addr  out  FPGA_ADDR_WIDTH  address of the first mismatch
// BEHAVIOUR
//  Reset: fpga_reset, asynchronous, active-high; clock fpga_clk.
//  - On reset all outputs are 0 and the state is IDLE.
//  - Reset mid-run drops fpga_req/wr_en/rd_en immediately (async); the run is not resumed.
//  Address: addr(i) = BASE_ADDR + i*ADDR_STRIDE, truncated to FPGA_ADDR_WIDTH (wraps).
//  - Bank = top SDRAM_BANK_WIDTH bits; row = [COL+ROW-1:COL]; col = [COL-1:0].
//  Pattern: data(a) = SEED ^ {zero-ext a} ^ {a[7:0],24'h0}.
//  - Recomputed at read time; there is no storage of written data.
//  States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN, ABORT.
//  - IDLE: start -> clear err_count, first_err_addr, done, timeout; i=0; latch mode; -> WR_REQ.
//    Start while busy is ignored.
//  - WR_REQ: assert fpga_req=1, wr_en=1, addr(i), data(addr(i)).
//    All held stable until fpga_ack=1 is sampled at a posedge, then -> WR_GAP.
//  - WR_GAP: exactly one cycle with req, wr_en and rd_en = 0.
//    Block mode: i<NUM_XFERS-1 -> i++, WR_REQ; else i=0, RD_REQ.
//    Interleaved mode: -> RD_REQ with the same i.
//  - RD_REQ: assert req=1, rd_en=1, addr(i), held until ack.
//    In the ack cycle compare fpga_rd_data with data(addr(i)).
//    On a mismatch, err_count++ (saturating at all-ones).
//    On the first mismatch, load first_err_addr.
//    Then -> RD_GAP.
//  - RD_GAP: one idle cycle.
//    If i==NUM_XFERS-1 -> FIN.
//    Otherwise i++, then -> RD_REQ (block mode) or WR_REQ (interleaved mode).
//  - FIN: done=1, pass computed, -> IDLE in the same cycle (done stays set).
//  - Timeout: the watchdog clears on entry to each REQ state.
//    If it reaches ACK_TIMEOUT-1 without ack -> ABORT: req dropped, timeout=1, done=1, pass=0, -> IDLE.
//  - An ack seen in a GAP or IDLE cycle is ignored; it is not counted.
//  - busy=1 from the cycle after an accepted start until done rises.
//  - fpga_wr_data is 0 when wr_en=0.
//  Latency:
//    Block run ≈ 2*NUM_XFERS*(ack latency + 2) cycles.
//    Minimum per transfer is 2 cycles (ack in the first REQ cycle).
// STRUCTURE
//  - sdram_tg_pkg.vh: state encodings, MODE_BLOCK/MODE_INTERLEAVE localparams, pattern function.
//  - Sub-module sdram_tg_pattern: combinational addr/data generator (index -> addr, data).
//    Shared by the write and compare paths.
//  - Top level holds the FSM, index counter, watchdog and result registers.
// TESTING  (DUT driving sdram_controller + SDRAM model, or a behavioural ack model)
//  1 NUM_XFERS=4, BASE=0, mode=0, ack after 3 cycles
//    -> 4 writes, then 4 reads at 0..3; done=1, pass=1, err_count=0.
//  2 mode=1, BASE=23'h1FFE01 (bank0 row 0xFFF col 1), STRIDE=1
//    -> req order W0 R0 W1 R1 ...; pass=1.
//  3 Model corrupts the read of addr 2 (bit0 flipped)
//    -> err_count=1, first_err_addr=2, pass=0.
//  4 BASE=23'h7FFFFE, NUM_XFERS=4
//    -> addresses 7FFFFE, 7FFFFF, 000000, 000001 (wrap); pass=1.
//  5 Model never acks; ACK_TIMEOUT=16
//    -> req drops after 16 cycles; timeout=1, done=1, pass=0.
//  6 fpga_reset asserted mid WR_REQ
//    -> req/wr_en low with no clock edge; start pulse afterwards runs clean, pass=1.
//    Extra start pulses while busy are ignored.

Source files
------------

// File: rtl/sdram_tg_pkg.sv
// Shared types and helpers for the SDRAM traffic generator: FSM encoding,
// run-mode constants and the address-derived data pattern.
package sdram_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_GAP,
    ST_FIN,
    ST_ABORT
  } tg_state_t;

  localparam logic MODE_BLOCK      = 1'b0;
  localparam logic MODE_INTERLEAVE = 1'b1;

  // Widest data/address the pattern helper handles; callers truncate.
  localparam int unsigned PAT_MAX_W = 64;

  // data(a) = seed ^ a ^ (a[7:0] placed in the top byte of the data word).
  function automatic logic [PAT_MAX_W-1:0] tg_pattern(
    input logic [PAT_MAX_W-1:0] seed,
    input logic [PAT_MAX_W-1:0] addr,
    input int unsigned          data_width
  );
    logic [PAT_MAX_W-1:0] top_byte;
    top_byte = {{(PAT_MAX_W-8){1'b0}}, addr[7:0]} << (data_width - 8);
    return seed ^ addr ^ top_byte;
  endfunction

endpackage

// File: rtl/sdram_tg_pattern.sv
// Combinational index -> (address, data) generator; shared by the write path
// and the read-compare path so both always agree on the expected word.
module sdram_tg_pattern
  import sdram_tg_pkg::*;
#(
  parameter int unsigned                 FPGA_ADDR_WIDTH = 23,
  parameter int unsigned                 FPGA_DATA_WIDTH = 32,
  parameter int unsigned                 IDX_WIDTH       = 4,
  parameter int unsigned                 ADDR_STRIDE     = 1,
  parameter logic [FPGA_ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
  parameter logic [FPGA_DATA_WIDTH-1:0]  SEED            = 32'hA5A5_0000
) (
  input  logic [IDX_WIDTH-1:0]       idx,
  output logic [FPGA_ADDR_WIDTH-1:0] addr,
  output logic [FPGA_DATA_WIDTH-1:0] data
);

  // Address arithmetic is done wide and truncated so large bases wrap cleanly.
  always_comb begin
    addr = FPGA_ADDR_WIDTH'(64'(BASE_ADDR) + 64'(idx) * 64'(ADDR_STRIDE));
    data = FPGA_DATA_WIDTH'(tg_pattern(PAT_MAX_W'(SEED), PAT_MAX_W'(addr),
                                       FPGA_DATA_WIDTH));
  end

endmodule

// File: rtl/sdram_traffic_gen.sv
// Write/read-back traffic generator for the sdram_controller host port:
// FSM, transfer index, ack watchdog and sticky run-result registers.
module sdram_traffic_gen
  import sdram_tg_pkg::*;
#(
  parameter int unsigned                 FPGA_ADDR_WIDTH = 23,
  parameter int unsigned                 FPGA_DATA_WIDTH = 32,
  parameter int unsigned                 NUM_XFERS       = 16,
  parameter int unsigned                 ADDR_STRIDE     = 1,
  parameter logic [FPGA_ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
  parameter logic [FPGA_DATA_WIDTH-1:0]  SEED            = 32'hA5A5_0000,
  parameter int unsigned                 ACK_TIMEOUT     = 1024,
  parameter int unsigned                 ERR_CNT_WIDTH   = 16
) (
  input  logic                       fpga_clk,
  input  logic                       fpga_reset,
  input  logic                       start,
  input  logic                       mode,
  output logic [FPGA_ADDR_WIDTH-1:0] fpga_addr,
  output logic                       fpga_wr_en,
  output logic [FPGA_DATA_WIDTH-1:0] fpga_wr_data,
  output logic                       fpga_rd_en,
  output logic                       fpga_req,
  input  logic                       fpga_ack,
  input  logic [FPGA_DATA_WIDTH-1:0] fpga_rd_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [ERR_CNT_WIDTH-1:0]   err_count,
  output logic [FPGA_ADDR_WIDTH-1:0] first_err_addr
);

  localparam int unsigned IDX_W = (NUM_XFERS > 1) ? $clog2(NUM_XFERS) : 1;
  localparam int unsigned WD_W  = $clog2(ACK_TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_XFERS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(ACK_TIMEOUT - 1);

  tg_state_t state_q, state_d;

  logic [IDX_W-1:0]           idx_q;
  logic [WD_W-1:0]            wd_q;
  logic                       mode_q;
  logic                       run_start;
  logic                       idx_inc;
  logic                       idx_clr;
  logic                       rd_mismatch;
  logic [FPGA_ADDR_WIDTH-1:0] pat_addr;
  logic [FPGA_DATA_WIDTH-1:0] pat_data;

  sdram_tg_pattern #(
    .FPGA_ADDR_WIDTH (FPGA_ADDR_WIDTH),
    .FPGA_DATA_WIDTH (FPGA_DATA_WIDTH),
    .IDX_WIDTH       (IDX_W),
    .ADDR_STRIDE     (ADDR_STRIDE),
    .BASE_ADDR       (BASE_ADDR),
    .SEED            (SEED)
  ) u_pattern (
    .idx  (idx_q),
    .addr (pat_addr),
    .data (pat_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Host outputs decode straight from the state register, so an async reset
  // drops the request strobes without waiting for a clock edge.
  always_comb begin
    // NOTE: every signal written here gets a default first; a missed branch
    // would otherwise infer a latch.
    state_d      = state_q;
    run_start    = 1'b0;
    idx_inc      = 1'b0;
    idx_clr      = 1'b0;
    fpga_req     = 1'b0;
    fpga_wr_en   = 1'b0;
    fpga_rd_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          run_start = 1'b1;
          state_d   = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        fpga_req   = 1'b1;
        fpga_wr_en = 1'b1;
        if (fpga_ack)              state_d = ST_WR_GAP;
        else if (wd_q == WD_LAST)  state_d = ST_ABORT;
      end
      ST_WR_GAP: begin
        if (mode_q == MODE_INTERLEAVE) begin
          state_d = ST_RD_REQ;
        end else if (idx_q == LAST_IDX) begin
          idx_clr = 1'b1;
          state_d = ST_RD_REQ;
        end else begin
          idx_inc = 1'b1;
          state_d = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        fpga_req   = 1'b1;
        fpga_rd_en = 1'b1;
        if (fpga_ack)              state_d = ST_RD_GAP;
        else if (wd_q == WD_LAST)  state_d = ST_ABORT;
      end
      ST_RD_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_FIN;
        end else begin
          idx_inc = 1'b1;
          state_d = (mode_q == MODE_INTERLEAVE) ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign fpga_addr    = fpga_req   ? pat_addr : '0;
  assign fpga_wr_data = fpga_wr_en ? pat_data : '0;
  assign rd_mismatch  = (state_q == ST_RD_REQ) && fpga_ack && (fpga_rd_data != pat_data);

  // Index and watchdog; the watchdog restarts on every entry to a REQ state
  // because every REQ state is entered from a non-REQ state.
  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset) begin
      idx_q  <= '0;
      wd_q   <= '0;
      mode_q <= MODE_BLOCK;
    end else begin
      if (run_start) begin
        idx_q  <= '0;
        mode_q <= mode;
      end else if (idx_clr) begin
        idx_q  <= '0;
      end else if (idx_inc) begin
        idx_q  <= idx_q + IDX_W'(1);
      end

      if (state_q == ST_WR_REQ || state_q == ST_RD_REQ) wd_q <= wd_q + WD_W'(1);
      else                                              wd_q <= '0;
    end
  end

  // Sticky run results, cleared only by an accepted start.
  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset) begin
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (run_start) begin
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (rd_mismatch) begin
        if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
        if (err_count == '0) first_err_addr <= pat_addr;
      end
      if (state_q == ST_FIN) begin
        done <= 1'b1;
        pass <= (err_count == '0) && !timeout;
      end
      if (state_q == ST_ABORT) begin
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Scoreboard bench: two generator instances (base 0 and a wrapping base)
// against a behavioural ack/memory model with programmable latency.
module tb_sdram_traffic_gen;

  localparam int AW = 23;
  localparam int DW = 32;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic fpga_clk;
  logic fpga_reset;

  logic          start_a [2];
  logic          mode_a  [2];
  logic [AW-1:0] addr_a  [2];
  logic          wr_a    [2];
  logic [DW-1:0] wdata_a [2];
  logic          rd_a    [2];
  logic          req_a   [2];
  logic          busy_a  [2];
  logic          done_a  [2];
  logic          pass_a  [2];
  logic          to_a    [2];
  logic [15:0]   err_a   [2];
  logic [AW-1:0] first_a [2];

  int            lat        [2];
  bit            no_ack     [2];
  bit            corrupt_en;
  logic [AW-1:0] corrupt_addr;

  txn_t exp_q [2][$];
  int   n_checks;
  int   n_errors;

  // Hand-computed address/data vectors (seed A5A5_0000).
  logic [AW-1:0] addr_lo   [4] = '{23'h000000, 23'h000001, 23'h000002, 23'h000003};
  logic [DW-1:0] data_lo   [4] = '{32'hA5A5_0000, 32'hA4A5_0001, 32'hA7A5_0002, 32'hA6A5_0003};
  logic [AW-1:0] addr_wrap [4] = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};
  logic [DW-1:0] data_wrap [4] = '{32'h5BDA_FFFE, 32'h5ADA_FFFF, 32'hA5A5_0000, 32'hA4A5_0001};

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic [AW-1:0] BASE = (g == 0) ? 23'h000000 : 23'h7FFFFE;

    logic          ack;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            cnt;

    sdram_traffic_gen #(
      .FPGA_ADDR_WIDTH (AW),
      .FPGA_DATA_WIDTH (DW),
      .NUM_XFERS       (4),
      .ADDR_STRIDE     (1),
      .BASE_ADDR       (BASE),
      .SEED            (32'hA5A5_0000),
      .ACK_TIMEOUT     (16),
      .ERR_CNT_WIDTH   (16)
    ) u_dut (
      .fpga_clk       (fpga_clk),
      .fpga_reset     (fpga_reset),
      .start          (start_a[g]),
      .mode           (mode_a[g]),
      .fpga_addr      (addr_a[g]),
      .fpga_wr_en     (wr_a[g]),
      .fpga_wr_data   (wdata_a[g]),
      .fpga_rd_en     (rd_a[g]),
      .fpga_req       (req_a[g]),
      .fpga_ack       (ack),
      .fpga_rd_data   (rd_data),
      .busy           (busy_a[g]),
      .done           (done_a[g]),
      .pass           (pass_a[g]),
      .timeout        (to_a[g]),
      .err_count      (err_a[g]),
      .first_err_addr (first_a[g])
    );

    // Controller model: ack 'lat' cycles into each request, one cycle wide.
    initial begin
      ack     = 1'b0;
      rd_data = '0;
      cnt     = 0;
    end
    always @(posedge fpga_clk) begin
      #1;
      if (fpga_reset || !req_a[g]) begin
        cnt = 0;
        ack = 1'b0;
      end else if (!ack) begin
        cnt++;
        if (!no_ack[g] && cnt >= lat[g]) begin
          ack = 1'b1;
          if (wr_a[g]) mem[addr_a[g]] = wdata_a[g];
          if (rd_a[g]) begin
            rd_data = mem.exists(addr_a[g]) ? mem[addr_a[g]] : '0;
            if (g == 0 && corrupt_en && addr_a[g] == corrupt_addr) rd_data[0] = ~rd_data[0];
          end
        end
      end
    end

    // Monitor: every accepted request must be the next expected transaction.
    always @(negedge fpga_clk) begin
      txn_t t;
      if (!fpga_reset && req_a[g] && ack) begin
        check($sformatf("txn_expected_inst%0d", g), exp_q[g].size() != 0, 1);
        if (exp_q[g].size() != 0) begin
          t = exp_q[g].pop_front();
          check($sformatf("txn_inst%0d_addr%0h", g, t.addr),
                {wr_a[g], rd_a[g], addr_a[g], wdata_a[g]},
                {t.wr, ~t.wr, t.addr, t.data});
        end
      end
    end
  end

  task automatic push(input int g, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.wr   = wr;
    t.addr = a;
    t.data = wr ? d : '0;
    exp_q[g].push_back(t);
  endtask

  task automatic push_run(input int g, input logic m, input logic [AW-1:0] at [4],
                          input logic [DW-1:0] dt [4]);
    if (m == 1'b0) begin
      for (int i = 0; i < 4; i++) push(g, 1'b1, at[i], dt[i]);
      for (int i = 0; i < 4; i++) push(g, 1'b0, at[i], '0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        push(g, 1'b1, at[i], dt[i]);
        push(g, 1'b0, at[i], '0);
      end
    end
  endtask

  task automatic run(input int g, input logic m, input int extra_starts, input string name,
                     input logic exp_pass, input logic exp_to, input logic [15:0] exp_err,
                     input logic [AW-1:0] exp_first, input int exp_req_cycles);
    int req_cycles;
    bit seen;
    @(negedge fpga_clk);
    start_a[g] = 1'b1;
    mode_a[g]  = m;
    @(negedge fpga_clk);
    start_a[g] = 1'b0;
    check({name, "_busy_after_start"}, {busy_a[g], done_a[g]}, 2'b10);
    req_cycles = int'(req_a[g]);
    for (int k = 0; k < extra_starts; k++) begin
      @(negedge fpga_clk);
      start_a[g] = 1'b1;
      mode_a[g]  = ~m;
      @(negedge fpga_clk);
      start_a[g] = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge fpga_clk);
      if (done_a[g]) seen = 1'b1;
      else if (req_a[g]) req_cycles++;
    end
    check({name, "_done"}, seen, 1'b1);
    check({name, "_pass_timeout_busy"}, {pass_a[g], to_a[g], busy_a[g]}, {exp_pass, exp_to, 1'b0});
    check({name, "_err_count"}, err_a[g], exp_err);
    check({name, "_first_err_addr"}, first_a[g], exp_first);
    check({name, "_all_txns_seen"}, exp_q[g].size(), 0);
    if (exp_req_cycles >= 0) check({name, "_req_cycles"}, req_cycles, exp_req_cycles);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got=expired expected=finish");
    $fatal(1);
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    fpga_reset   = 1'b1;
    corrupt_en   = 1'b0;
    corrupt_addr = '0;
    for (int g = 0; g < 2; g++) begin
      start_a[g] = 1'b0;
      mode_a[g]  = 1'b0;
      lat[g]     = 3;
      no_ack[g]  = 1'b0;
    end
    repeat (3) @(negedge fpga_clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("reset_outputs_inst%0d", g),
            {req_a[g], wr_a[g], rd_a[g], busy_a[g], done_a[g], pass_a[g], to_a[g],
             err_a[g], first_a[g], addr_a[g], wdata_a[g]}, '0);
    fpga_reset = 1'b0;
    repeat (2) @(negedge fpga_clk);

    // Block run, ack latency 3.
    push_run(0, 1'b0, addr_lo, data_lo);
    run(0, 1'b0, 0, "block", 1'b1, 1'b0, 16'd0, '0, -1);

    // Interleaved run: W0 R0 W1 R1 ...
    push_run(0, 1'b1, addr_lo, data_lo);
    run(0, 1'b1, 0, "interleave", 1'b1, 1'b0, 16'd0, '0, -1);

    // Corrupted read of address 2.
    corrupt_en   = 1'b1;
    corrupt_addr = 23'h000002;
    push_run(0, 1'b0, addr_lo, data_lo);
    run(0, 1'b0, 0, "corrupt", 1'b0, 1'b0, 16'd1, 23'h000002, -1);
    corrupt_en   = 1'b0;

    // Address wrap at the top of the 23-bit space.
    push_run(1, 1'b1, addr_wrap, data_wrap);
    run(1, 1'b1, 0, "wrap", 1'b1, 1'b0, 16'd0, '0, -1);

    // No ack: request held exactly ACK_TIMEOUT cycles, then abort.
    no_ack[0] = 1'b1;
    run(0, 1'b0, 0, "ack_timeout", 1'b0, 1'b1, 16'd0, '0, 16);
    no_ack[0] = 1'b0;

    // Async reset in the middle of a write request.
    lat[0] = 10;
    @(negedge fpga_clk);
    start_a[0] = 1'b1;
    mode_a[0]  = 1'b0;
    @(negedge fpga_clk);
    start_a[0] = 1'b0;
    @(negedge fpga_clk);
    check("midrun_req_before_reset", {req_a[0], wr_a[0]}, 2'b11);
    @(posedge fpga_clk);
    #3;
    fpga_reset = 1'b1;
    #1;
    check("midrun_async_drop", {req_a[0], wr_a[0], rd_a[0], busy_a[0], addr_a[0], wdata_a[0]}, '0);
    check("midrun_reset_status", {done_a[0], pass_a[0], to_a[0]}, 3'b000);
    @(negedge fpga_clk);
    @(negedge fpga_clk);
    fpga_reset = 1'b0;
    lat[0]     = 3;

    // Clean run afterwards, with stray start pulses while busy.
    push_run(0, 1'b0, addr_lo, data_lo);
    run(0, 1'b0, 2, "after_reset", 1'b1, 1'b0, 16'd0, '0, -1);
    repeat (20) @(negedge fpga_clk);
    check("idle_after_run_req_done", {req_a[0], busy_a[0], done_a[0]}, 3'b001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
